// File: rtl/robot_pkg.sv
// Move codes shared with the robot motor FSM, plus the scheduler state encoding.
package robot_pkg;

    localparam logic [2:0] MV_STOP  = 3'b000;
    localparam logic [2:0] MV_FWD   = 3'b111;
    localparam logic [2:0] MV_LEFT  = 3'b101;
    localparam logic [2:0] MV_RIGHT = 3'b110;
    localparam logic [2:0] MV_BACK  = 3'b011;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_WAKE,
        ST_IDLE,
        ST_RUN,
        ST_DOWN
    } sched_state_e;

endpackage

// File: rtl/robot_cmd_fifo.sv
// Synchronous command FIFO with a flush that still honors a same-cycle push.
module robot_cmd_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Depth is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= do_push ? AW'(1) : '0;
            count_q  <= do_push ? (AW+1)'(1) : '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[flush_i ? '0 : wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/robot_cmd_sched.sv
// Command scheduler for the tracked robot: queues timed moves, sequences motor
// power, and arbitrates between the queue, the live override and the obstacle tracker.
module robot_cmd_sched
    import robot_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int DUR_W      = 8,
    parameter int WAKE_TO    = 16,
    parameter int IDLE_TO    = 64
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [2:0]       cmd_move_i,
    input  logic [DUR_W-1:0] cmd_dur_i,
    input  logic             rc_req_i,
    input  logic [2:0]       rc_move_i,
    output logic             motor_on_o,
    input  logic             motor_status_i,
    output logic [2:0]       move_o,
    input  logic             tracker_status_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             blocked_o,
    output logic             err_o
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int WK_W  = $clog2(WAKE_TO + 1);
    localparam int ID_W  = $clog2(IDLE_TO + 1);

    sched_state_e     state_q, state_d;
    logic [2:0]       move_q, move_d;
    logic [2:0]       cur_move_q, cur_move_d;
    logic [DUR_W-1:0] dur_q, dur_d;
    logic [WK_W-1:0]  wake_cnt_q, wake_cnt_d;
    logic [ID_W-1:0]  idle_cnt_q, idle_cnt_d;
    logic             motor_on_q, motor_on_d;
    logic             done_q, done_d;
    logic             blocked_q, blocked_d;
    logic             err_q, err_d;

    logic             cmd_push, fifo_pop, fifo_flush;
    logic             fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_cnt;
    logic [DUR_W+2:0] fifo_rdata;
    logic [2:0]       head_move;
    logic [DUR_W-1:0] head_dur;
    logic             unused_full;

    assign cmd_ready_o = (fifo_cnt != CNT_W'(FIFO_DEPTH));
    assign cmd_push    = cmd_valid_i && cmd_ready_o;
    assign head_move   = fifo_rdata[DUR_W+2:DUR_W];
    assign head_dur    = fifo_rdata[DUR_W-1:0];
    assign unused_full = fifo_full;

    robot_cmd_fifo #(
        .WIDTH (DUR_W + 3),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .push_i  (cmd_push),
        .pop_i   (fifo_pop),
        .flush_i (fifo_flush),
        .wdata_i ({cmd_move_i, cmd_dur_i}),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    always_comb begin
        state_d    = state_q;
        move_d     = MV_STOP;
        cur_move_d = cur_move_q;
        dur_d      = dur_q;
        wake_cnt_d = wake_cnt_q;
        idle_cnt_d = idle_cnt_q;
        motor_on_d = motor_on_q;
        done_d     = 1'b0;
        blocked_d  = 1'b0;
        err_d      = err_q;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;

        // A wake timeout later in this block takes precedence over the clear.
        if (cmd_push) err_d = 1'b0;

        unique case (state_q)
            ST_OFF: begin
                motor_on_d = 1'b0;
                if (!fifo_empty || rc_req_i) begin
                    state_d    = ST_WAKE;
                    motor_on_d = 1'b1;
                    wake_cnt_d = '0;
                end
            end
            ST_WAKE: begin
                motor_on_d = 1'b1;
                if (motor_status_i) begin
                    state_d    = ST_IDLE;
                    idle_cnt_d = '0;
                end else if (wake_cnt_q == WK_W'(WAKE_TO - 1)) begin
                    err_d      = 1'b1;
                    fifo_flush = 1'b1;
                    motor_on_d = 1'b0;
                    state_d    = ST_DOWN;
                end else begin
                    wake_cnt_d = wake_cnt_q + WK_W'(1);
                end
            end
            ST_IDLE: begin
                if (!motor_status_i) begin
                    state_d    = ST_WAKE;
                    wake_cnt_d = '0;
                end else if (rc_req_i) begin
                    move_d     = rc_move_i;
                    idle_cnt_d = '0;
                end else if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    cur_move_d = head_move;
                    dur_d      = (head_dur == '0) ? DUR_W'(1) : head_dur;
                    move_d     = head_move;
                    state_d    = ST_RUN;
                end else if (idle_cnt_q == ID_W'(IDLE_TO - 1)) begin
                    motor_on_d = 1'b0;
                    state_d    = ST_DOWN;
                end else begin
                    idle_cnt_d = idle_cnt_q + ID_W'(1);
                end
            end
            ST_RUN: begin
                // Power loss drops the command; tracker abort beats override beats countdown.
                if (!motor_status_i) begin
                    state_d    = ST_WAKE;
                    wake_cnt_d = '0;
                end else if (tracker_status_i && cur_move_q == MV_FWD) begin
                    blocked_d  = 1'b1;
                    dur_d      = '0;
                    idle_cnt_d = '0;
                    state_d    = ST_IDLE;
                end else if (rc_req_i) begin
                    move_d = rc_move_i;
                end else if (dur_q == DUR_W'(1)) begin
                    done_d     = 1'b1;
                    dur_d      = '0;
                    idle_cnt_d = '0;
                    state_d    = ST_IDLE;
                end else begin
                    dur_d  = dur_q - DUR_W'(1);
                    move_d = cur_move_q;
                end
            end
            ST_DOWN: begin
                motor_on_d = 1'b0;
                if (!motor_status_i) state_d = ST_OFF;
            end
            default: begin
                state_d    = ST_OFF;
                motor_on_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= ST_OFF;
            move_q     <= MV_STOP;
            cur_move_q <= MV_STOP;
            dur_q      <= '0;
            wake_cnt_q <= '0;
            idle_cnt_q <= '0;
            motor_on_q <= 1'b0;
            done_q     <= 1'b0;
            blocked_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            move_q     <= move_d;
            cur_move_q <= cur_move_d;
            dur_q      <= dur_d;
            wake_cnt_q <= wake_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            motor_on_q <= motor_on_d;
            done_q     <= done_d;
            blocked_q  <= blocked_d;
            err_q      <= err_d;
        end
    end

    assign move_o     = move_q;
    assign motor_on_o = motor_on_q;
    assign done_o     = done_q;
    assign blocked_o  = blocked_q;
    assign err_o      = err_q;
    assign busy_o     = (state_q != ST_OFF);

endmodule
